// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU arbiter: RV32I funct3 codes, ALU select encodings, FSM states.
package alu_ctrl_pkg;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [1:0] EXEC_ADD = 2'b00;
   localparam logic [1:0] EXEC_CMP = 2'b01;
   localparam logic [1:0] EXEC_LOG = 2'b10;
   localparam logic [1:0] EXEC_SHF = 2'b11;

   localparam logic [1:0] SH_SLL = 2'b00;
   localparam logic [1:0] SH_SRL = 2'b10;
   localparam logic [1:0] SH_SRA = 2'b11;

   localparam logic [1:0] LOG_XOR = 2'b00;
   localparam logic [1:0] LOG_OR  = 2'b01;
   localparam logic [1:0] LOG_AND = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic [1:0] sel_exec_out;
      logic       sel_a;
      logic       sel_comp;
      logic [1:0] sel_s;
      logic [1:0] sel_l;
      logic       illegal;
   } alu_sel_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-drive signals of the shared-ALU arbiter; slave is the arbiter side.
interface alu_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid, req0_ready;
   logic [3:0]       req0_op;
   logic [WIDTH-1:0] req0_a, req0_b;
   logic             req1_valid, req1_ready;
   logic [3:0]       req1_op;
   logic [WIDTH-1:0] req1_a, req1_b;

   logic             rsp_valid, rsp_ready, rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_z, rsp_c, rsp_n, rsp_err;

   logic [WIDTH-1:0] alu_srcA, alu_srcB;
   logic             alu_sel_a, alu_sel_comp;
   logic [1:0]       alu_sel_s, alu_sel_l, alu_sel_exec_out;
   logic [WIDTH-1:0] alu_exec_out;
   logic             alu_z, alu_c, alu_n;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_data, rsp_z, rsp_c, rsp_n, rsp_err,
      input  rsp_ready,
      output alu_srcA, alu_srcB, alu_sel_a, alu_sel_comp, alu_sel_s, alu_sel_l, alu_sel_exec_out,
      input  alu_exec_out, alu_z, alu_c, alu_n
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_data, rsp_z, rsp_c, rsp_n, rsp_err,
      output rsp_ready,
      input  alu_srcA, alu_srcB, alu_sel_a, alu_sel_comp, alu_sel_s, alu_sel_l, alu_sel_exec_out,
      output alu_exec_out, alu_z, alu_c, alu_n
   );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational decode of {funct7[5], funct3} into ALU select lines plus an illegal flag.
// Illegal encodings return all selects at zero so the ALU never sees a partial decode.
module alu_op_decode
   import alu_ctrl_pkg::*;
(
   input  logic [3:0] op,
   output alu_sel_t   sel
);
   always_comb begin
      sel = '0;
      case (op[2:0])
         F3_ADD: begin
            sel.sel_exec_out = EXEC_ADD;
            sel.sel_a        = op[3];
         end
         F3_SLL: begin
            sel.sel_exec_out = EXEC_SHF;
            sel.sel_s        = SH_SLL;
         end
         F3_SLT: begin
            sel.sel_exec_out = EXEC_CMP;
            sel.sel_a        = 1'b1;
            sel.sel_comp     = 1'b1;
         end
         F3_SLTU: begin
            sel.sel_exec_out = EXEC_CMP;
            sel.sel_a        = 1'b1;
         end
         F3_XOR: begin
            sel.sel_exec_out = EXEC_LOG;
            sel.sel_l        = LOG_XOR;
         end
         F3_SR: begin
            sel.sel_exec_out = EXEC_SHF;
            sel.sel_s        = op[3] ? SH_SRA : SH_SRL;
         end
         F3_OR: begin
            sel.sel_exec_out = EXEC_LOG;
            sel.sel_l        = LOG_OR;
         end
         F3_AND: begin
            sel.sel_exec_out = EXEC_LOG;
            sel.sel_l        = LOG_AND;
         end
         default: sel = '0;
      endcase
      // funct7[5] only qualifies add/sub and srl/sra
      if (op[3] && (op[2:0] != F3_ADD) && (op[2:0] != F3_SR)) begin
         sel         = '0;
         sel.illegal = 1'b1;
      end
   end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin shares one execution ALU between two requesters; accept at T, ALU at T+1, response at T+2.
// A stalled response holds RESP indefinitely and blocks both request ports.
module alu_arbiter
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   alu_arbiter_if.slave bus
);
   state_t           state;
   logic             last_grant;
   logic             id_q;
   logic             grant0, grant1;
   logic [3:0]       win_op;
   alu_sel_t         win_sel, sel_q;
   logic [WIDTH-1:0] src_a_q, src_b_q, rsp_data_q;
   logic             rsp_valid_q, rsp_id_q, rsp_z_q, rsp_c_q, rsp_n_q, rsp_err_q;

   // On a tie the port that was not granted last wins
   assign grant1 = (state == ST_IDLE) && bus.req1_valid && (!bus.req0_valid || !last_grant);
   assign grant0 = (state == ST_IDLE) && bus.req0_valid && !grant1;

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;

   assign win_op = grant1 ? bus.req1_op : bus.req0_op;

   alu_op_decode u_dec (
      .op  (win_op),
      .sel (win_sel)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         last_grant  <= 1'b1;
         id_q        <= 1'b0;
         sel_q       <= '0;
         src_a_q     <= '0;
         src_b_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         rsp_z_q     <= 1'b0;
         rsp_c_q     <= 1'b0;
         rsp_n_q     <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant0 || grant1) begin
                  last_grant <= grant1;
                  id_q       <= grant1;
                  sel_q      <= win_sel;
                  src_a_q    <= grant1 ? bus.req1_a : bus.req0_a;
                  src_b_q    <= grant1 ? bus.req1_b : bus.req0_b;
                  state      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               // Illegal ops still take the full latency but report nothing from the ALU
               rsp_data_q  <= sel_q.illegal ? '0 : bus.alu_exec_out;
               rsp_z_q     <= !sel_q.illegal && bus.alu_z;
               rsp_c_q     <= !sel_q.illegal && bus.alu_c;
               rsp_n_q     <= !sel_q.illegal && bus.alu_n;
               rsp_err_q   <= sel_q.illegal;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               sel_q       <= '0;
               src_a_q     <= '0;
               src_b_q     <= '0;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_z     = rsp_z_q;
   assign bus.rsp_c     = rsp_c_q;
   assign bus.rsp_n     = rsp_n_q;
   assign bus.rsp_err   = rsp_err_q;

   assign bus.alu_srcA         = src_a_q;
   assign bus.alu_srcB         = src_b_q;
   assign bus.alu_sel_a        = sel_q.sel_a;
   assign bus.alu_sel_comp     = sel_q.sel_comp;
   assign bus.alu_sel_s        = sel_q.sel_s;
   assign bus.alu_sel_l        = sel_q.sel_l;
   assign bus.alu_sel_exec_out = sel_q.sel_exec_out;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on the alu_* port, cycle model scoreboard, directed vectors.
module tb_alu_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu_arbiter_if #(.WIDTH(32)) bus ();

   alu_arbiter #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Parent-side ALU, interpreting the select lines
   logic [32:0] alu_sum;
   logic [31:0] alu_res;
   logic        alu_cy;
   assign alu_sum = {1'b0, bus.alu_srcA} + {1'b0, bus.alu_sel_a ? ~bus.alu_srcB : bus.alu_srcB}
                  + {32'd0, bus.alu_sel_a};
   always_comb begin
      alu_res = '0;
      alu_cy  = 1'b0;
      case (bus.alu_sel_exec_out)
         2'b00: begin alu_res = alu_sum[31:0]; alu_cy = alu_sum[32]; end
         2'b01: begin
            if (bus.alu_sel_comp) alu_res = ($signed(bus.alu_srcA) < $signed(bus.alu_srcB)) ? 32'd1 : 32'd0;
            else                  alu_res = (bus.alu_srcA < bus.alu_srcB) ? 32'd1 : 32'd0;
            alu_cy = alu_sum[32];
         end
         2'b10: begin
            case (bus.alu_sel_l)
               2'b00:   alu_res = bus.alu_srcA ^ bus.alu_srcB;
               2'b01:   alu_res = bus.alu_srcA | bus.alu_srcB;
               2'b10:   alu_res = bus.alu_srcA & bus.alu_srcB;
               default: alu_res = '0;
            endcase
         end
         default: begin
            case (bus.alu_sel_s)
               2'b00:   alu_res = bus.alu_srcA << bus.alu_srcB[4:0];
               2'b10:   alu_res = bus.alu_srcA >> bus.alu_srcB[4:0];
               2'b11:   alu_res = $signed(bus.alu_srcA) >>> bus.alu_srcB[4:0];
               default: alu_res = '0;
            endcase
         end
      endcase
   end
   assign bus.alu_exec_out = alu_res;
   assign bus.alu_z        = (alu_res == 32'd0);
   assign bus.alu_c        = alu_cy;
   assign bus.alu_n        = alu_res[31];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // RV32I semantics: {id, err, z, c, n, data}; c is the adder carry (a + ~b + 1 for sub/compares)
   function automatic logic [36:0] model(input logic id, input logic [3:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum, dif;
      logic [31:0] r;
      logic        c, err;
      sum = {1'b0, a} + {1'b0, b};
      dif = {1'b0, a} + {1'b0, ~b} + 33'd1;
      r = '0; c = 1'b0; err = 1'b0;
      case (op)
         4'b0000: begin r = sum[31:0]; c = sum[32]; end
         4'b1000: begin r = dif[31:0]; c = dif[32]; end
         4'b0001: r = a << b[4:0];
         4'b0010: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; c = dif[32]; end
         4'b0011: begin r = (a < b) ? 32'd1 : 32'd0; c = dif[32]; end
         4'b0100: r = a ^ b;
         4'b0101: r = a >> b[4:0];
         4'b1101: r = $signed(a) >>> b[4:0];
         4'b0110: r = a | b;
         4'b0111: r = a & b;
         default: err = 1'b1;
      endcase
      return {id, err, !err && (r == 32'd0), c, r[31], r};
   endfunction

   // Scoreboard: one op in flight at most; response due two cycles after accept
   bit          m_pending = 1'b0;
   bit          m_last = 1'b1;
   int          m_acc = 0;
   int          cyc = 0;
   logic [36:0] m_exp;
   logic [31:0] m_a, m_b;
   logic        e0, e1, exp_vld;

   always @(negedge clk) begin
      if (rst) begin
         m_pending = 1'b0;
         m_last    = 1'b1;
      end else begin
         e0 = 1'b0;
         e1 = 1'b0;
         if (!m_pending) begin
            e1 = bus.req1_valid && (!bus.req0_valid || !m_last);
            e0 = bus.req0_valid && !e1;
         end
         chk("ready", {bus.req1_ready, bus.req0_ready}, {e1, e0});
         exp_vld = m_pending && (cyc >= m_acc + 2);
         chk("rsp_valid", bus.rsp_valid, exp_vld);
         if (m_pending && cyc == m_acc + 1)
            chk("alu_operands", {bus.alu_srcA, bus.alu_srcB}, {m_a, m_b});
         else
            chk("alu_idle", {|bus.alu_srcA, |bus.alu_srcB, bus.alu_sel_a, bus.alu_sel_comp,
                             bus.alu_sel_s, bus.alu_sel_l, bus.alu_sel_exec_out}, 64'd0);
         if (exp_vld)
            chk("rsp_fields", {bus.rsp_id, bus.rsp_err, bus.rsp_z, bus.rsp_c, bus.rsp_n, bus.rsp_data}, m_exp);
         if (exp_vld && bus.rsp_ready) begin
            m_pending = 1'b0;
         end else if (e0 || e1) begin
            m_pending = 1'b1;
            m_acc     = cyc;
            m_last    = e1;
            m_a       = e1 ? bus.req1_a : bus.req0_a;
            m_b       = e1 ? bus.req1_b : bus.req0_b;
            m_exp     = model(e1, e1 ? bus.req1_op : bus.req0_op, m_a, m_b);
         end
      end
      cyc++;
   end

   task automatic drive(input bit port, input bit vld, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      if (port) begin
         bus.req1_valid = vld; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
      end else begin
         bus.req0_valid = vld; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
      end
   endtask

   task automatic wait_ready(input string name, output bit ok, output bit gid);
      ok = 1'b0; gid = 1'b0;
      for (int i = 0; i < 12 && !ok; i++) begin
         @(negedge clk);
         if (bus.req0_ready || bus.req1_ready) begin ok = 1'b1; gid = bus.req1_ready; end
      end
      if (!ok) chk({name, "_accept_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic wait_rsp(input string name, output int lat);
      bit ok;
      ok = 1'b0; lat = 0;
      for (int i = 0; i < 12 && !ok; i++) begin
         @(negedge clk);
         lat++;
         if (bus.rsp_valid) ok = 1'b1;
      end
      if (!ok) chk({name, "_rsp_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic do_op(input string name, input bit port, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic exp_z, input logic exp_err);
      bit ok, gid;
      int lat;
      drive(port, 1'b1, op, a, b);
      bus.rsp_ready = 1'b1;
      wait_ready(name, ok, gid);
      chk({name, "_grant"}, gid, port);
      @(posedge clk); #1;
      drive(port, 1'b0, 4'd0, 32'd0, 32'd0);
      wait_rsp(name, lat);
      chk({name, "_latency"}, lat, 2);
      chk({name, "_id"}, bus.rsp_id, port);
      chk({name, "_data"}, bus.rsp_data, exp_d);
      chk({name, "_z"}, bus.rsp_z, exp_z);
      chk({name, "_err"}, bus.rsp_err, exp_err);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok, gid;
      int lat;
      drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
      drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
      bus.rsp_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ctrl", {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id,
                       bus.rsp_z, bus.rsp_c, bus.rsp_n, bus.rsp_err}, 64'd0);
      chk("rst_data", bus.rsp_data, 64'd0);
      chk("rst_alu", {bus.alu_srcA, bus.alu_srcB}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      do_op("add", 0, 4'b0000, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
      do_op("sub", 1, 4'b1000, 32'd555, 32'd555, 32'd0, 1'b1, 1'b0);
      do_op("sra", 1, 4'b1101, 32'hFFFF_FF80, 32'd7, 32'hFFFF_FFFF, 1'b0, 1'b0);

      // Both ports continuously valid: grants alternate starting at port 0
      drive(0, 1'b1, 4'b0010, 32'hF000_0000, 32'd34);
      drive(1, 1'b1, 4'b0011, 32'hF000_0000, 32'd34);
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_ready("alt", ok, gid);
         chk("alt_grant", gid, k % 2);
         @(posedge clk); #1;
         if (k == 3) begin
            drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
            drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
         end
         wait_rsp("alt", lat);
         chk("alt_id", bus.rsp_id, k % 2);
         chk("alt_data", bus.rsp_data, (k % 2) ? 32'd0 : 32'd1);
         @(posedge clk); #1;
      end

      // Backpressure: response held, competing request must wait
      bus.rsp_ready = 1'b0;
      drive(0, 1'b1, 4'b0100, 32'hFF00_FF00, 32'h0F0F_0F0F);
      wait_ready("bp", ok, gid);
      @(posedge clk); #1;
      drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
      drive(1, 1'b1, 4'b0000, 32'd7, 32'd8);
      wait_rsp("bp", lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_data", bus.rsp_data, 32'hF00F_F00F);
         chk("bp_hold", {bus.rsp_valid, bus.req1_ready, bus.req0_ready}, 3'b100);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_release", {bus.req1_ready, bus.req0_ready}, 2'b10);
      @(posedge clk); #1;
      drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
      wait_rsp("bp2", lat);
      chk("bp2_data", {bus.rsp_id, bus.rsp_data}, {1'b1, 32'd15});
      @(posedge clk); #1;

      do_op("illegal", 0, 4'b1100, 32'd5, 32'd3, 32'd0, 1'b0, 1'b1);

      // Reset during EXEC aborts the response and restores the pointer
      drive(0, 1'b1, 4'b0000, 32'd10, 32'd20);
      wait_ready("abort", ok, gid);
      @(posedge clk); #1;
      drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_rsp", bus.rsp_valid, 1'b0);
      end
      @(posedge clk); #1;
      drive(0, 1'b1, 4'b0111, 32'hF0F0_F0F0, 32'h3C3C_3C3C);
      drive(1, 1'b1, 4'b0110, 32'd1, 32'd2);
      @(negedge clk);
      chk("ptr_after_rst", {bus.req1_ready, bus.req0_ready}, 2'b01);
      @(posedge clk); #1;
      drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
      drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
      wait_rsp("and", lat);
      chk("and_data", bus.rsp_data, 32'h3030_3030);
      @(posedge clk); #1;
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle execution ALU between two requesters (e.g. the integer datapath and the branch/address path of the multicycle core). It round-robin arbitrates valid/ready requests carrying an RV32I ALU opcode and two operands. It decodes the opcode into the ALU select lines, drives the ALU from registered operands, captures result and flags, and returns a tagged response. The ALU is instantiated by the parent; this block owns all of its inputs.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  4  {funct7[5], funct3}
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester index of response
- rsp_data  out  WIDTH  ALU result
- rsp_z, rsp_c, rsp_n  out  1  captured zero/carry/negative flags
- rsp_err  out  1  illegal opcode
- alu_srcA, alu_srcB  out  WIDTH  ALU operands
- alu_sel_a, alu_sel_comp  out  1  add/sub, slt/sltu select
- alu_sel_s, alu_sel_l, alu_sel_exec_out  out  2  shift, logic, output-mux select
- alu_exec_out  in  WIDTH; alu_z, alu_c, alu_n  in  1  ALU result/flags

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: winner = sole valid port; if both are valid, the port not granted last. Winner's ready is high combinationally; on valid&&ready, latch op/a/b/id, toggle the last-grant pointer to the winner, go to EXEC. No valid: stay IDLE.
- EXEC: drive the ALU from latched regs and decoded selects. At clock edge, capture alu_exec_out and the flags into response regs, go to RESP.
- RESP: rsp_valid=1. On rsp_ready go to IDLE. Response fields are stable while rsp_valid && !rsp_ready.
- Decode of funct3 and funct7[5], giving sel_exec_out/sel_a/sel_comp/sel_s/sel_l:
  - 000/0 add: 00/0. 000/1 sub: 00/1.
  - 001 sll: 11, sel_s=00. 101/0 srl: 11, sel_s=10. 101/1 sra: 11, sel_s=11.
  - 010 slt: 01, sel_a=1, sel_comp=1. 011 sltu: 01, sel_a=1, sel_comp=0.
  - 100 xor: 10, sel_l=00. 110 or: 10, sel_l=01. 111 and: 10, sel_l=10.
  - All unused selects are driven 0, never X.
- Illegal: funct7[5]=1 with funct3 other than 000 or 101. Result is rsp_err=1, rsp_data=0, flags 0, still 3-cycle latency.
- Outside EXEC all alu_* outputs are 0.
- Requesters hold valid/op/operands stable until ready. Ready is never high in EXEC/RESP.

## Timing
- Reset state: IDLE. Last-grant pointer = 1, so port 0 wins the first tie.
- Reset outputs: req*_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, flags 0, rsp_err=0, alu_* = 0.
- Accept at cycle T, EXEC at T+1, rsp_valid at T+2.
- With rsp_ready=1 at T+2, the next accept is possible at T+3, giving a peak of 1 op / 3 cycles.
- Backpressure: RESP is held indefinitely; no new request is accepted meanwhile.
- rst in any state aborts the operation: no response, pointer reset, returns to IDLE on the next cycle.
- A request arriving during EXEC/RESP waits; arbitration uses valids sampled in IDLE only.

## Structure
- Package alu_ctrl_pkg holds:
  - funct3 opcode localparams;
  - sel_exec_out encodings (ADD=00, CMP=01, LOG=10, SHF=11);
  - sel_s/sel_l encodings;
  - FSM state typedef.
- Sub-module alu_op_decode: combinational op[3:0] -> five select fields + illegal. Reusable by the main decoder.

## Test plan
- Reset: assert rst 2 cycles -> all outputs 0, state IDLE.
- req0 op=0000, a=1, b=1 -> req0_ready at T; at T+2 rsp_valid=1, rsp_id=0, rsp_data=2, rsp_z=0.
- req1 op=1000 (sub), a=555, b=555 -> rsp_data=0, rsp_z=1. Then op=1101 (sra), a=-128, b=7 -> rsp_data=0xFFFFFFFF.
- Both valid continuously: req0 op=0010 (slt), a=0xF0000000, b=34; req1 op=0011 (sltu), same operands:
  - grants alternate 0,1,0,1;
  - responses 1 (slt) and 0 (sltu) tagged correctly.
- rsp_ready held low 5 cycles in RESP -> rsp fields stable, req ready stays 0; release -> next accept the following cycle.
- req0 op=1100 (illegal) -> rsp_err=1, rsp_data=0. Reset asserted during EXEC of another request -> no rsp_valid afterwards.
